hex_keypad_scanner: RTL and testbench
=====================================

// Module: hex_keypad_scanner
// PURPOSE
//  Input-side counterpart of the multiplexed 4-digit hex display. Scans a 4x4 hex keypad
//  by driving columns active-low and reading rows, then debounces. Each accepted press
//  emits one key_valid pulse with a 4-bit key code and shifts the digit into a 16-bit
//  hex_val register. hex_val feeds the display and CPU inputs in the top-level.
// PARAMETERS
//  SCAN_DIV        100_000  clk cycles per scan tick (1 kHz at 100 MHz); min 4
//  DEBOUNCE_SCANS  4        consecutive identical tick samples to accept a press or release; min 2
// PORTS
//  clk         in   1   system clock (100 MHz domain)
//  reset_n     in   1   asynchronous active-low reset
//  kp_row_in   in   4   keypad rows; active-low; pulled up; asynchronous to clk
//  kp_col_out  out  4   keypad column drive; active-low; exactly one bit low at all times
//  clr         in   1   synchronous clear of hex_val
//  key_valid   out  1   one-cycle pulse per accepted press
//  key_code    out  4   code of the last accepted key; held until the next press
//  key_held    out  1   high while an accepted key is still down (until release is debounced)
//  hex_val     out  16  shift register of entered digits; newest digit in [3:0]
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): kp_col_out=4'b1110, key_valid=0,
//   key_code=0, key_held=0, hex_val=0, state=SCAN, col_idx=0, tick and debounce counters=0.
//  kp_row_in passes through a 2-FF synchronizer (reset to 4'b1111); all logic uses synced rows (rs).
//  Tick: one-cycle pulse every SCAN_DIV clks from a free-running counter, which wraps at SCAN_DIV-1.
//   Rows are sampled only on a tick, so the column is stable for SCAN_DIV cycles before sampling.
//  Valid sample: rs has exactly one 0 bit (one-hot-low). All-ones = idle. Two or more zeros = invalid.
//  FSM (one transition per tick at most):
//   SCAN:     on tick: valid sample -> latch row_idx, cnt=1, go DEBOUNCE (column frozen);
//             otherwise col_idx=col_idx+1 (mod 4, 3->0), update kp_col_out.
//   DEBOUNCE: on tick: rs equals the latched pattern -> cnt++; when cnt reaches DEBOUNCE_SCANS:
//             go PRESSED, key_valid=1 for that cycle, key_code=KEYMAP[row][col], key_held=1.
//             rs differs (bounce, release or invalid) -> cnt=0, go SCAN; column is not advanced.
//   PRESSED:  column frozen; on tick: rs==4'b1111 -> cnt++, else cnt=0;
//             when cnt reaches DEBOUNCE_SCANS: key_held=0, go SCAN, advance column.
//  A key held for any length produces exactly one key_valid (no auto-repeat).
//  A second key pressed while in PRESSED is ignored; release requires all rows high.
//  KEYMAP (rows 0..3 x cols 0..3): 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
//  hex_val: on the key_valid edge, hex_val <= {hex_val[11:0], key_code}; the top nibble is discarded.
//   clr has priority: clr and key_valid in the same cycle -> hex_val=0, digit dropped.
//   key_valid and key_code still pulse and update.
//  Latency: key_valid asserts on the clk edge of the DEBOUNCE_SCANS-th matching tick
//   (the first match counts as 1). hex_val and key_code update on that same edge.
//  Reset mid-operation: all state returns to reset values immediately; no pulse is emitted.
// STRUCTURE
//  keypad_pkg: FSM state encoding (SCAN, DEBOUNCE, PRESSED), KEYMAP constant table,
//   and the one-hot-low check and row-index encode functions.
//  Sub-module scan_tick_gen (parameter SCAN_DIV; ports clk, reset_n, tick) provides the tick.
//  Synchronizer, FSM, debounce counter and hex_val shift register are in this module.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3, keypad behavioural model driving rows)
//  1 reset: rows idle for 20 ticks -> kp_col_out cycles 1110,1101,1011,0111,1110; no key_valid.
//  2 press '5' (row1,col1) held 10 ticks -> exactly one key_valid; key_code=4'h5; hex_val=16'h0005.
//    Release for 3 ticks -> key_held falls, column advances.
//  3 bounce: '9' toggles every tick for 6 ticks, then stable -> one key_valid only after 3 stable ticks.
//  4 press 1,2,3,4,5 in sequence -> hex_val=16'h2345; five key_valid pulses.
//  5 '4' and '7' together (rows1,2 in col0) -> no key_valid; scanning continues.
//    Then clr coincident with key 'E' -> hex_val=0, key_code=4'hE.
//  6 reset_n low during DEBOUNCE for key 'A' -> outputs at reset values that cycle, no pulse.
//    After release, 'A' held -> key_valid with key_code=4'hA.

Source files
------------

// File: rtl/hex_keypad_scanner_pkg.sv
// Shared definitions for the hex keypad scanner: FSM state encoding,
// key code table and small row/column decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } kp_state_e;

  // Synchronised rows with no key pulling any row low.
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Key codes indexed by {row, col}; row 0 is the top row of the keypad.
  localparam logic [0:15][3:0] KEYMAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // True when exactly one row is pulled low (a single unambiguous key).
  function automatic logic one_hot_low(input logic [3:0] rows);
    logic res;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Index of the low row; only meaningful when one_hot_low() holds.
  function automatic logic [1:0] row_encode(input logic [3:0] rows);
    logic [1:0] res;
    case (rows)
      4'b1101: res = 2'd1;
      4'b1011: res = 2'd2;
      4'b0111: res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

  // Active-low column drive pattern with only column 'col' pulled low.
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and host-side signals of the hex keypad scanner.
// slave: the scanner itself; master: whatever drives the rows and reads the keys.
interface hex_keypad_scanner_if;

  logic [3:0]  kp_row_in;
  logic [3:0]  kp_col_out;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] hex_val;

  modport slave (
    input  kp_row_in,
    input  clr,
    output kp_col_out,
    output key_valid,
    output key_code,
    output key_held,
    output hex_val
  );

  modport master (
    output kp_row_in,
    output clr,
    input  kp_col_out,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  hex_val
  );

endinterface

// File: rtl/hex_keypad_scanner_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks.
// The tick paces column scanning and debounce sampling.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int               CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count 0..SCAN_DIV-1 and wrap.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one column low at a time, samples the
// synchronised rows on each scan tick, debounces press and release, and
// shifts each accepted digit into hex_val.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hex_keypad_scanner_if.slave   bus
);

  localparam int           DB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  logic        tick;

  // Two-stage row synchroniser; rs is the only row view used by the logic.
  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [3:0]  rs;

  kp_state_e   state_q,     state_d;
  logic [1:0]  col_idx_q,   col_idx_d;
  logic [3:0]  col_out_q,   col_out_d;
  logic [3:0]  row_pat_q,   row_pat_d;
  logic [1:0]  row_idx_q,   row_idx_d;
  logic [DB_W-1:0] cnt_q,   cnt_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q,  key_code_d;
  logic        key_held_q,  key_held_d;
  logic [15:0] hex_val_q,   hex_val_d;

  logic [DB_W-1:0] cnt_inc;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Bring the asynchronous keypad rows into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= ROWS_IDLE;
      sync2_q <= ROWS_IDLE;
    end else begin
      sync1_q <= bus.kp_row_in;
      sync2_q <= sync1_q;
    end
  end

  assign rs      = sync2_q;
  assign cnt_inc = cnt_q + DB_W'(1);

  // Scan/debounce FSM and hex_val shift register next-state logic.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    col_out_d   = col_out_q;
    row_pat_d   = row_pat_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    hex_val_d   = hex_val_q;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (one_hot_low(rs)) begin
            // Freeze the column and remember which row went low; this
            // sample is the first of the debounce run.
            row_pat_d = rs;
            row_idx_d = row_encode(rs);
            cnt_d     = DB_W'(1);
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            col_out_d = col_drive(col_idx_q + 2'd1);
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (rs == row_pat_q) begin
            if (cnt_inc == DB_TARGET) begin
              cnt_d       = '0;
              state_d     = PRESSED;
              key_valid_d = 1'b1;
              key_code_d  = key_lookup(row_idx_q, col_idx_q);
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Bounce, early release or a second key: rescan this column.
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end

      PRESSED: begin
        if (tick) begin
          if (rs == ROWS_IDLE) begin
            if (cnt_inc == DB_TARGET) begin
              cnt_d      = '0;
              key_held_d = 1'b0;
              state_d    = SCAN;
              col_idx_d  = col_idx_q + 2'd1;
              col_out_d  = col_drive(col_idx_q + 2'd1);
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase

    // clr wins over a digit arriving in the same cycle.
    if (bus.clr) begin
      hex_val_d = '0;
    end else if (key_valid_d) begin
      hex_val_d = {hex_val_q[11:0], key_code_d};
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      col_out_q   <= 4'b1110;
      row_pat_q   <= ROWS_IDLE;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
      hex_val_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_out_q   <= col_out_d;
      row_pat_q   <= row_pat_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      hex_val_q   <= hex_val_d;
    end
  end

  assign bus.kp_col_out = col_out_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;
  assign bus.key_held   = key_held_q;
  assign bus.hex_val    = hex_val_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a behavioural 4x4 keypad model.
module tb_hex_keypad_scanner;

  logic        clk;
  logic        reset_n;
  logic [15:0] key_down;   // bit r*4+c set = key at row r, column c is pressed
  logic [3:0]  rows_model;
  int          n_cmp;
  int          n_bad;
  int          kv_count;

  hex_keypad_scanner_if kp_if ();

  hex_keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows_model = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_down[r*4+c] && !kp_if.kp_col_out[c]) rows_model[r] = 1'b0;
      end
    end
  end
  assign kp_if.kp_row_in = rows_model;

  // Count key_valid pulses (value seen just before each edge).
  always @(posedge clk) begin
    if (reset_n && kp_if.key_valid) kv_count <= kv_count + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (kp_if.key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_held_fall(input int max_cyc, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (kp_if.key_held === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_col(input logic [3:0] col, input int max_cyc, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (kp_if.kp_col_out === col) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] prev;
    logic [3:0] exp_col;
    int         changes;
    bit         saw_kv;
    reset_n      = 1'b0;
    key_down     = '0;
    kp_if.clr    = 1'b0;
    cycles(3);
    n_cmp++; if (kp_if.kp_col_out !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b expected 1110", kp_if.kp_col_out); end
    n_cmp++; if (kp_if.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b expected 0", kp_if.key_valid); end
    n_cmp++; if (kp_if.key_code !== 4'h0) begin n_bad++; $display("FAIL reset_key_code: got %h expected 0", kp_if.key_code); end
    n_cmp++; if (kp_if.key_held !== 1'b0) begin n_bad++; $display("FAIL reset_key_held: got %b expected 0", kp_if.key_held); end
    n_cmp++; if (kp_if.hex_val !== 16'h0000) begin n_bad++; $display("FAIL reset_hex_val: got %h expected 0000", kp_if.hex_val); end
    reset_n = 1'b1;
    prev    = 4'b1110;
    changes = 0;
    saw_kv  = 1'b0;
    // 20 idle ticks: columns rotate 1110,1101,1011,0111,1110,...
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (kp_if.key_valid !== 1'b0) saw_kv = 1'b1;
      if (kp_if.kp_col_out !== prev) begin
        changes++;
        exp_col = ~(4'b0001 << (changes % 4));
        n_cmp++; if (kp_if.kp_col_out !== exp_col) begin n_bad++; $display("FAIL idle_col_seq: step %0d got %b expected %b", changes, kp_if.kp_col_out, exp_col); end
        prev = kp_if.kp_col_out;
      end
    end
    n_cmp++; if (changes != 20) begin n_bad++; $display("FAIL idle_col_changes: got %0d expected 20", changes); end
    n_cmp++; if (saw_kv) begin n_bad++; $display("FAIL idle_no_key_valid: got pulse expected none"); end
    $display("test_reset done: %0d column steps", changes);
  endtask

  task automatic test_press_five();
    bit ok;
    int n;
    int kv0;
    kv0         = kv_count;
    key_down[5] = 1'b1;
    wait_valid(80, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL press5_pulse: got timeout expected key_valid"); end
    n_cmp++; if (kp_if.key_code !== 4'h5) begin n_bad++; $display("FAIL press5_code: got %h expected 5", kp_if.key_code); end
    n_cmp++; if (kp_if.hex_val !== 16'h0005) begin n_bad++; $display("FAIL press5_hex: got %h expected 0005", kp_if.hex_val); end
    n_cmp++; if (kp_if.key_held !== 1'b1) begin n_bad++; $display("FAIL press5_held: got %b expected 1", kp_if.key_held); end
    cycles(40);
    n_cmp++; if (kv_count - kv0 != 1) begin n_bad++; $display("FAIL press5_one_pulse: got %0d expected 1", kv_count - kv0); end
    n_cmp++; if (kp_if.kp_col_out !== 4'b1101) begin n_bad++; $display("FAIL press5_col_frozen: got %b expected 1101", kp_if.kp_col_out); end
    key_down[5] = 1'b0;
    wait_held_fall(60, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL press5_release: got timeout expected key_held low"); end
    n_cmp++; if (n < 8) begin n_bad++; $display("FAIL press5_release_time: got %0d cycles expected >= 8", n); end
    n_cmp++; if (kp_if.kp_col_out !== 4'b1011) begin n_bad++; $display("FAIL press5_col_advance: got %b expected 1011", kp_if.kp_col_out); end
    $display("test_press_five done: code %h hex %h", kp_if.key_code, kp_if.hex_val);
  endtask

  task automatic test_bounce();
    bit ok;
    int n;
    int kv0;
    kv0 = kv_count;
    // '9' is row 2, column 2; toggles once per tick so no two samples agree.
    for (int i = 0; i < 6; i++) begin
      key_down[10] = (i % 2 == 0);
      cycles(4);
    end
    n_cmp++; if (kv_count != kv0) begin n_bad++; $display("FAIL bounce_no_pulse: got %0d pulses expected 0", kv_count - kv0); end
    key_down[10] = 1'b1;
    wait_valid(80, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bounce_pulse: got timeout expected key_valid"); end
    n_cmp++; if (n < 8) begin n_bad++; $display("FAIL bounce_latency: got %0d cycles expected >= 8", n); end
    n_cmp++; if (kp_if.key_code !== 4'h9) begin n_bad++; $display("FAIL bounce_code: got %h expected 9", kp_if.key_code); end
    n_cmp++; if (kp_if.hex_val !== 16'h0059) begin n_bad++; $display("FAIL bounce_hex: got %h expected 0059", kp_if.hex_val); end
    key_down[10] = 1'b0;
    wait_held_fall(60, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bounce_release: got timeout expected key_held low"); end
    n_cmp++; if (kv_count - kv0 != 1) begin n_bad++; $display("FAIL bounce_one_pulse: got %0d expected 1", kv_count - kv0); end
    $display("test_bounce done: code %h hex %h", kp_if.key_code, kp_if.hex_val);
  endtask

  task automatic test_back_to_back();
    int         idx [5] = '{0, 1, 2, 4, 5};
    logic [3:0] code[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    bit ok;
    int n;
    int kv0;
    kv0 = kv_count;
    for (int k = 0; k < 5; k++) begin
      key_down[idx[k]] = 1'b1;
      wait_valid(80, ok, n);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_pulse[%0d]: got timeout expected key_valid", k); end
      n_cmp++; if (kp_if.key_code !== code[k]) begin n_bad++; $display("FAIL seq_code[%0d]: got %h expected %h", k, kp_if.key_code, code[k]); end
      key_down[idx[k]] = 1'b0;
      wait_held_fall(60, ok, n);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_release[%0d]: got timeout expected key_held low", k); end
      $display("test_back_to_back key %0d: code %h hex %h", k, kp_if.key_code, kp_if.hex_val);
    end
    n_cmp++; if (kp_if.hex_val !== 16'h2345) begin n_bad++; $display("FAIL seq_hex: got %h expected 2345", kp_if.hex_val); end
    n_cmp++; if (kv_count - kv0 != 5) begin n_bad++; $display("FAIL seq_pulses: got %0d expected 5", kv_count - kv0); end
  endtask

  task automatic test_multi_and_clr();
    logic [3:0] prev;
    int changes;
    int kv0;
    bit ok;
    int n;
    kv0         = kv_count;
    // '4' and '7' share column 0: two low rows is an invalid sample.
    key_down[4] = 1'b1;
    key_down[8] = 1'b1;
    prev    = kp_if.kp_col_out;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kp_if.kp_col_out !== prev) begin
        changes++;
        prev = kp_if.kp_col_out;
      end
    end
    n_cmp++; if (changes < 9) begin n_bad++; $display("FAIL multi_scanning: got %0d column steps expected >= 9", changes); end
    n_cmp++; if (kv_count != kv0) begin n_bad++; $display("FAIL multi_no_pulse: got %0d pulses expected 0", kv_count - kv0); end
    key_down[4] = 1'b0;
    key_down[8] = 1'b0;
    cycles(8);
    // clr held across the whole 'E' press so it coincides with the pulse.
    kp_if.clr    = 1'b1;
    key_down[14] = 1'b1;
    wait_valid(80, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL clr_e_pulse: got timeout expected key_valid"); end
    n_cmp++; if (kp_if.hex_val !== 16'h0000) begin n_bad++; $display("FAIL clr_e_hex: got %h expected 0000", kp_if.hex_val); end
    n_cmp++; if (kp_if.key_code !== 4'hE) begin n_bad++; $display("FAIL clr_e_code: got %h expected e", kp_if.key_code); end
    kp_if.clr    = 1'b0;
    key_down[14] = 1'b0;
    wait_held_fall(60, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL clr_e_release: got timeout expected key_held low"); end
    $display("test_multi_and_clr done: %0d column steps, hex %h", changes, kp_if.hex_val);
  endtask

  task automatic test_reset_mid_debounce();
    bit ok;
    int n;
    int kv0;
    wait_col(4'b1110, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_wait_col0: got timeout expected column 0"); end
    kv0         = kv_count;
    key_down[3] = 1'b1;   // 'A' is row 0, column 3
    wait_col(4'b0111, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_wait_col3: got timeout expected column 3"); end
    // Detection happens 4 edges after the column change; pulse would be at 12.
    cycles(6);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (kp_if.kp_col_out !== 4'b1110) begin n_bad++; $display("FAIL rst_mid_col: got %b expected 1110", kp_if.kp_col_out); end
    n_cmp++; if (kp_if.key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", kp_if.key_valid); end
    n_cmp++; if (kp_if.key_code !== 4'h0) begin n_bad++; $display("FAIL rst_mid_code: got %h expected 0", kp_if.key_code); end
    n_cmp++; if (kp_if.key_held !== 1'b0) begin n_bad++; $display("FAIL rst_mid_held: got %b expected 0", kp_if.key_held); end
    n_cmp++; if (kp_if.hex_val !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_hex: got %h expected 0000", kp_if.hex_val); end
    key_down[3] = 1'b0;
    cycles(4);
    n_cmp++; if (kv_count != kv0) begin n_bad++; $display("FAIL rst_mid_no_pulse: got %0d pulses expected 0", kv_count - kv0); end
    reset_n = 1'b1;
    cycles(8);
    key_down[3] = 1'b1;
    wait_valid(80, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_a_pulse: got timeout expected key_valid"); end
    n_cmp++; if (kp_if.key_code !== 4'hA) begin n_bad++; $display("FAIL rst_a_code: got %h expected a", kp_if.key_code); end
    n_cmp++; if (kp_if.hex_val !== 16'h000A) begin n_bad++; $display("FAIL rst_a_hex: got %h expected 000a", kp_if.hex_val); end
    key_down[3] = 1'b0;
    wait_held_fall(60, ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_a_release: got timeout expected key_held low"); end
    $display("test_reset_mid_debounce done: code %h hex %h", kp_if.key_code, kp_if.hex_val);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    kv_count = 0;
    reset_n  = 1'b0;
    key_down = '0;
    kp_if.clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_press_five();
    test_bounce();
    test_back_to_back();
    test_multi_and_clr();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
